// File: rtl/tb_seq_pkg.sv
// Shared encodings for the TB port-B read sequencer: op codes, mapper select codes, FSM states.
package tb_seq_pkg;

    localparam logic [2:0] OP_B_POS        = 3'd0;
    localparam logic [2:0] OP_B_NEG        = 3'd1;
    localparam logic [2:0] OP_B_NEW        = 3'd2;
    localparam logic [2:0] OP_BC_TRANSPOSE = 3'd3;

    localparam logic [4:0] SEL_IDLE         = 5'b00000;
    localparam logic [4:0] SEL_B_POS        = 5'b00101;
    localparam logic [4:0] SEL_B_NEG        = 5'b00110;
    localparam logic [4:0] SEL_B_NEW        = 5'b00111;
    localparam logic [4:0] SEL_BC_TRANSPOSE = 5'b11000;

    localparam int unsigned TRANSPOSE_LEN_DEFAULT = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [4:0] sel_for_op(input logic [2:0] op);
        case (op)
            OP_B_POS:        return SEL_B_POS;
            OP_B_NEG:        return SEL_B_NEG;
            OP_B_NEW:        return SEL_B_NEW;
            OP_BC_TRANSPOSE: return SEL_BC_TRANSPOSE;
            default:         return SEL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tb_seq_align_pipe.sv
// DEPTH-stage shift register that delays issue-side {sel, seq, l_k_0} to line up with TB_doutb.
module tb_seq_align_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 11
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/tb_doutb_seq_ctrl.sv
// TB port-B read sequencer with read-latency-aligned mapper select/seq/l_k_0.
// Optional macro TB_SEQ_PERF_EN adds saturating busy-cycle and op counters.
module tb_doutb_seq_ctrl
    import tb_seq_pkg::*;
#(
    parameter int unsigned SEQ_CNT_DW      = 5,
    parameter int unsigned TB_AW           = 10,
    parameter int unsigned TB_DOUTB_SEL_DW = 5,
    parameter int unsigned RD_LAT          = 2,
    parameter int unsigned TRANSPOSE_LEN   = TRANSPOSE_LEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       sys_rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic                       cmd_l_k_0,
    input  logic [TB_AW-1:0]           cmd_base_addr,
    input  logic [SEQ_CNT_DW-1:0]      cmd_len,
    output logic                       TB_enb,
    output logic [TB_AW-1:0]           TB_addrb,
    output logic [TB_DOUTB_SEL_DW-1:0] TB_doutb_sel,
    output logic                       l_k_0,
    output logic [SEQ_CNT_DW-1:0]      seq_cnt_out,
    output logic                       done,
`ifdef TB_SEQ_PERF_EN
    output logic [31:0]                perf_busy_cycles,
    output logic [15:0]                perf_ops,
`endif
    output logic                       err
);

    localparam int unsigned PIPE_DW = TB_DOUTB_SEL_DW + SEQ_CNT_DW + 1;

    state_t                  state_q, state_d;
    logic [2:0]              op_q;
    logic                    lk_q;
    logic [SEQ_CNT_DW-1:0]   len_q;
    logic [SEQ_CNT_DW-1:0]   seq_q;
    logic [TB_AW-1:0]        addr_q;
    logic [2:0]              lat_q;

    logic                    accept;
    logic                    cmd_legal;
    logic [SEQ_CNT_DW-1:0]   eff_len;
    logic                    last_beat;
    logic [PIPE_DW-1:0]      issue_bus;
    logic [PIPE_DW-1:0]      align_bus;

    assign cmd_legal = (cmd_op <= OP_BC_TRANSPOSE);
    assign eff_len   = (cmd_op == OP_BC_TRANSPOSE) ? SEQ_CNT_DW'(TRANSPOSE_LEN) : cmd_len;
    assign last_beat = (seq_q == len_q - SEQ_CNT_DW'(1));

    always_ff @(posedge clk) begin
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        TB_enb    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = ~sys_rst;
                if (cmd_valid && !sys_rst) begin
                    accept  = 1'b1;
                    state_d = (!cmd_legal || eff_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                TB_enb = 1'b1;
                if (last_beat) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (lat_q == 3'(RD_LAT - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                // Gated so a reset landing on the DONE cycle aborts without a pulse.
                done    = ~sys_rst;
                err     = ~sys_rst & (op_q > OP_BC_TRANSPOSE);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            op_q   <= '0;
            lk_q   <= 1'b0;
            len_q  <= '0;
            seq_q  <= '0;
            addr_q <= '0;
            lat_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= cmd_op;
                        lk_q  <= cmd_l_k_0;
                        len_q <= eff_len;
                        seq_q <= '0;
                        lat_q <= '0;
                        if (state_d == ST_ISSUE) addr_q <= cmd_base_addr;
                    end
                end
                ST_ISSUE: begin
                    if (!last_beat) begin
                        seq_q  <= seq_q + SEQ_CNT_DW'(1);
                        addr_q <= addr_q + TB_AW'(1);
                    end
                end
                ST_DRAIN: lat_q <= lat_q + 3'd1;
                ST_DONE:  seq_q <= '0;
                default: ;
            endcase
        end
    end

    assign TB_addrb  = addr_q;
    assign issue_bus = TB_enb ? {TB_DOUTB_SEL_DW'(sel_for_op(op_q)), seq_q, lk_q} : '0;

    tb_seq_align_pipe #(
        .DEPTH (RD_LAT),
        .DW    (PIPE_DW)
    ) u_align (
        .clk     (clk),
        .sys_rst (sys_rst),
        .din     (issue_bus),
        .dout    (align_bus)
    );

    assign {TB_doutb_sel, seq_cnt_out, l_k_0} = align_bus;

`ifdef TB_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            perf_busy_cycles <= '0;
            perf_ops         <= '0;
        end else begin
            if (state_q != ST_IDLE && perf_busy_cycles != '1)
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            if (done && perf_ops != '1)
                perf_ops <= perf_ops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tb_doutb_seq_ctrl.sv
// Directed table-driven bench for tb_doutb_seq_ctrl (RD_LAT=2, TB_AW=10).
module tb_tb_doutb_seq_ctrl;

    localparam int RD_LAT = 2;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_l_k_0;
    logic [9:0] cmd_base_addr;
    logic [4:0] cmd_len;
    logic       TB_enb;
    logic [9:0] TB_addrb;
    logic [4:0] TB_doutb_sel;
    logic       l_k_0;
    logic [4:0] seq_cnt_out;
    logic       done;
    logic       err;
`ifdef TB_SEQ_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_ops;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tb_doutb_seq_ctrl #(
        .SEQ_CNT_DW      (5),
        .TB_AW           (10),
        .TB_DOUTB_SEL_DW (5),
        .RD_LAT          (RD_LAT),
        .TRANSPOSE_LEN   (11)
    ) dut (
        .clk              (clk),
        .sys_rst          (sys_rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_l_k_0        (cmd_l_k_0),
        .cmd_base_addr    (cmd_base_addr),
        .cmd_len          (cmd_len),
        .TB_enb           (TB_enb),
        .TB_addrb         (TB_addrb),
        .TB_doutb_sel     (TB_doutb_sel),
        .l_k_0            (l_k_0),
        .seq_cnt_out      (seq_cnt_out),
        .done             (done),
`ifdef TB_SEQ_PERF_EN
        .perf_busy_cycles (perf_busy_cycles),
        .perf_ops         (perf_ops),
`endif
        .err              (err)
    );

    typedef struct {
        logic [2:0] op;
        logic       lk;
        logic [9:0] base;
        logic [4:0] len;
        int         eff;       // number of reads expected
        logic [4:0] sel;       // expected aligned select code
        int         done_cyc;  // cycle of the done pulse (accept = cycle 0)
        logic       err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one command at cycle 0, then during the busy cycles presents a
    // conflicting request that must be ignored (including a flipped cmd_l_k_0).
    task automatic run_vec(input vec_t v);
        logic       e_enb, e_act;
        logic [9:0] e_addr;
        for (int c = 0; c <= v.done_cyc + 1; c++) begin
            if (c == 0) begin
                cmd_valid = 1'b1; cmd_op = v.op; cmd_l_k_0 = v.lk;
                cmd_base_addr = v.base; cmd_len = v.len;
            end else if (c <= v.done_cyc) begin
                cmd_valid = 1'b1; cmd_op = 3'd1; cmd_l_k_0 = ~v.lk;
                cmd_base_addr = 10'h155; cmd_len = 5'd9;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            e_enb = (c >= 1) && (c <= v.eff);
            e_act = (c >= RD_LAT + 1) && (c <= RD_LAT + v.eff);
            chk("enb", c, 32'(TB_enb), 32'(e_enb));
            if (e_enb) begin
                e_addr = v.base + 10'(c - 1);
                chk("addr", c, 32'(TB_addrb), 32'(e_addr));
            end
            chk("sel", c, 32'(TB_doutb_sel), e_act ? 32'(v.sel) : 32'd0);
            chk("seq", c, 32'(seq_cnt_out), e_act ? 32'(c - RD_LAT - 1) : 32'd0);
            chk("lk", c, 32'(l_k_0), e_act ? 32'(v.lk) : 32'd0);
            chk("done", c, 32'(done), 32'(c == v.done_cyc));
            chk("err", c, 32'(err), 32'((c == v.done_cyc) && v.err));
            chk("ready", c, 32'(cmd_ready), 32'((c == 0) || (c == v.done_cyc + 1)));
            next_cycle();
        end
    endtask

    initial begin
        vecs[0] = '{op: 3'd0, lk: 1'b0, base: 10'h010, len: 5'd4, eff: 4,  sel: 5'b00101, done_cyc: 7,  err: 1'b0};
        vecs[1] = '{op: 3'd3, lk: 1'b1, base: 10'h100, len: 5'd3, eff: 11, sel: 5'b11000, done_cyc: 14, err: 1'b0};
        vecs[2] = '{op: 3'd2, lk: 1'b0, base: 10'h020, len: 5'd0, eff: 0,  sel: 5'b00000, done_cyc: 1,  err: 1'b0};
        vecs[3] = '{op: 3'd5, lk: 1'b0, base: 10'h030, len: 5'd4, eff: 0,  sel: 5'b00000, done_cyc: 1,  err: 1'b1};
        vecs[4] = '{op: 3'd1, lk: 1'b1, base: 10'h3FE, len: 5'd4, eff: 4,  sel: 5'b00110, done_cyc: 7,  err: 1'b0};
        vecs[5] = '{op: 3'd2, lk: 1'b0, base: 10'h005, len: 5'd1, eff: 1,  sel: 5'b00111, done_cyc: 4,  err: 1'b0};
        vecs[6] = '{op: 3'd7, lk: 1'b1, base: 10'h000, len: 5'd0, eff: 0,  sel: 5'b00000, done_cyc: 1,  err: 1'b1};

        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_l_k_0 = 1'b0;
        cmd_base_addr = '0; cmd_len = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_ready", 0, 32'(cmd_ready), 32'd0);
        chk("rst_enb", 0, 32'(TB_enb), 32'd0);
        chk("rst_addr", 0, 32'(TB_addrb), 32'd0);
        chk("rst_sel", 0, 32'(TB_doutb_sel), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        next_cycle();
        sys_rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 0, 32'(cmd_ready), 32'd1);
        next_cycle();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset on the seq=2 issue beat of B_NEG len=8 aborts silently.
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_l_k_0 = 1'b1; cmd_base_addr = 10'h040; cmd_len = 5'd8;
        next_cycle();
        cmd_valid = 1'b0;
        next_cycle();
        next_cycle();
        sys_rst = 1'b1;
        @(negedge clk);
        chk("abort_enb_pre", 3, 32'(TB_enb), 32'd1);
        chk("abort_addr_pre", 3, 32'(TB_addrb), 32'h042);
        chk("abort_sel_pre", 3, 32'(TB_doutb_sel), 32'b00110);
        next_cycle();
        sys_rst = 1'b0;
        for (int c = 4; c < 14; c++) begin
            @(negedge clk);
            chk("abort_enb", c, 32'(TB_enb), 32'd0);
            chk("abort_sel", c, 32'(TB_doutb_sel), 32'd0);
            chk("abort_seq", c, 32'(seq_cnt_out), 32'd0);
            chk("abort_lk", c, 32'(l_k_0), 32'd0);
            chk("abort_done", c, 32'(done), 32'd0);
            chk("abort_ready", c, 32'(cmd_ready), 32'd1);
            if (c == 4) chk("abort_addr", c, 32'(TB_addrb), 32'd0);
            next_cycle();
        end

        run_vec(vecs[0]);
        run_vec(vecs[4]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
